// File: rtl/clk_mgr_pkg.sv
// Shared types and helpers for the clk_mgr PLL supervisor.
package clk_mgr_pkg;

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        FILTER,
        RUN
    } state_e;

    localparam int unsigned RELOCK_W = 8;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_mgr_div.sv
// One clock-enable channel: divide-by-N counter with a pending/shadow divisor pair.
module clk_mgr_div
    import clk_mgr_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 run_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_wr_i,
    output logic                 clk_en_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [DIV_WIDTH-1:0] last;
    logic                 active;
    logic                 wrap;

    assign active   = run_i & en_i;
    // Divisors 0 and 1 both collapse to a terminal count of 0 (strobe every cycle).
    assign last     = (shadow_q <= DIV_WIDTH'(1)) ? '0 : shadow_q - DIV_WIDTH'(1);
    assign wrap     = active && (cnt_q == last);
    assign clk_en_o = wrap;

    always_comb begin
        cnt_d      = (active && !wrap) ? cnt_q + DIV_WIDTH'(1) : '0;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (pend_vld_q && (wrap || !active)) begin
            shadow_d   = pend_q;
            pend_vld_d = 1'b0;
        end
        if (div_wr_i) begin
            pend_d     = div_i;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q      <= '0;
            shadow_q   <= DIV_WIDTH'(1);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

endmodule

// File: rtl/clk_mgr.sv
// PLL supervisor and NUM_CH clock-enable generator on the reference clock.
// Define CLK_MGR_RELOCK_CNT_EN to implement the saturating relock counter.
module clk_mgr
    import clk_mgr_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned LOCK_FILTER  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 65536
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          pll_lock_i,
    input  logic [NUM_CH*DIV_WIDTH-1:0]   div_i,
    input  logic [NUM_CH-1:0]             div_wr_i,
    input  logic [NUM_CH-1:0]             ch_en_i,
    output logic                          pll_rst_o,
    output logic                          locked_o,
    output logic                          sys_rst_n_o,
    output logic [NUM_CH-1:0]             clk_en_o,
    output logic [RELOCK_W-1:0]           relock_cnt_o
);

    localparam int unsigned TMAX_A = (RST_HOLD > LOCK_FILTER) ? RST_HOLD : LOCK_FILTER;
    localparam int unsigned TMAX   = (TMAX_A > LOCK_TIMEOUT) ? TMAX_A : LOCK_TIMEOUT;
    localparam int unsigned TW     = cnt_w(TMAX);

    logic [1:0]    sync_q;
    logic          lock_s;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          relock_inc;
    logic          run_ok;

    assign lock_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= '0;
            state_q <= RESET_PLL;
            timer_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], pll_lock_i};
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TW'(1);
        relock_inc = 1'b0;
        case (state_q)
            RESET_PLL: begin
                if (timer_q == TW'(RST_HOLD - 1)) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = FILTER;
                    timer_d = '0;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    state_d    = RESET_PLL;
                    timer_d    = '0;
                    relock_inc = 1'b1;
                end
            end
            FILTER: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == TW'(LOCK_FILTER - 1)) begin
                    state_d = RUN;
                    timer_d = '0;
                end
            end
            RUN: begin
                timer_d = '0;
                if (!lock_s) begin
                    state_d    = RESET_PLL;
                    relock_inc = 1'b1;
                end
            end
            default: begin
                state_d = RESET_PLL;
                timer_d = '0;
            end
        endcase
    end

    // Gating on the synced lock drops the run outputs in the cycle the loss is seen.
    assign run_ok      = (state_q == RUN) && lock_s;
    assign pll_rst_o   = (state_q == RESET_PLL);
    assign locked_o    = run_ok;
    assign sys_rst_n_o = run_ok;

`ifdef CLK_MGR_RELOCK_CNT_EN
    logic [RELOCK_W-1:0] relock_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            relock_q <= '0;
        end else if (relock_inc && (relock_q != '1)) begin
            relock_q <= relock_q + RELOCK_W'(1);
        end
    end

    assign relock_cnt_o = relock_q;
`else
    logic unused_relock_inc;

    assign unused_relock_inc = relock_inc;
    assign relock_cnt_o      = '0;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_mgr_div #(
            .DIV_WIDTH(DIV_WIDTH)
        ) u_div (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .run_i   (run_ok),
            .en_i    (ch_en_i[k]),
            .div_i   (div_i[k*DIV_WIDTH +: DIV_WIDTH]),
            .div_wr_i(div_wr_i[k]),
            .clk_en_o(clk_en_o[k])
        );
    end

endmodule
